// File: rtl/fifo_param_thr.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, hysteretic pause output and a sticky,
// clearable overflow/underflow error flag. One instance per virtual channel.
module fifo_param_thr #(
    parameter int DATA_SIZE = 8,
    parameter int MAIN_SIZE = 6,
    parameter int CNT_W     = $clog2(MAIN_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in_push,
    input  logic [CNT_W-1:0]     thr_almost_full,
    input  logic [CNT_W-1:0]     thr_almost_empty,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 Fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int                PTR_W    = (MAIN_SIZE > 1) ? $clog2(MAIN_SIZE) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAIN_SIZE - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAIN_SIZE);

    logic [DATA_SIZE-1:0] mem [MAIN_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 pause_next;
    logic                 error_next;

    // Status flags decoded from the registered count and live thresholds
    always_comb begin
        Fifo_full    = (fifo_count == FULL_CNT);
        fifo_empty   = (fifo_count == '0);
        almost_full  = (fifo_count >= thr_almost_full);
        almost_empty = (fifo_count <= thr_almost_empty);
    end

    // Acceptance: a read frees a slot, so a full FIFO may still take a write
    always_comb begin
        rd_ok = read && !fifo_empty;
        wr_ok = write && (!Fifo_full || rd_ok);
    end

    // Next occupancy, pause and error state
    always_comb begin
        count_next = fifo_count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = fifo_count + CNT_W'(1);
            2'b01:   count_next = fifo_count - CNT_W'(1);
            default: count_next = fifo_count;
        endcase

        // Inverted thresholds give no hysteresis band: pause tracks the high mark only
        pause_next = fifo_pause;
        if (thr_almost_empty >= thr_almost_full) begin
            pause_next = (count_next >= thr_almost_full);
        end else if (count_next >= thr_almost_full) begin
            pause_next = 1'b1;
        end else if (count_next <= thr_almost_empty) begin
            pause_next = 1'b0;
        end

        // A fresh error takes priority over a clear request in the same cycle
        error_next = (write && !wr_ok) || (read && !rd_ok) || (fifo_error && !err_clr);
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in_push;
        end
    end

    // Pointers, count, registered pop data and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            data_out_pop <= '0;
            fifo_pause   <= 1'b0;
            fifo_error   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr       <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                data_out_pop <= mem[rd_ptr];
            end
            fifo_count <= count_next;
            fifo_pause <= pause_next;
            fifo_error <= error_next;
        end
    end

endmodule

// File: doc/fifo_param_thr.md
Name: fifo_param_thr

Overview:
- Parametrised synchronous FIFO; the next generation of the fixed 6x8 FIFO used in the PCIe switching datapath.
- Generalises data width and depth.
- Adds run-time programmable almost-full/almost-empty thresholds, an occupancy count output, a hysteretic pause (back-pressure) output and a clearable sticky error.
- Sits between the per-lane class demux and the arbiter, one instance per virtual channel.

Parameters:
- DATA_SIZE, 8, width of each FIFO word in bits.
- MAIN_SIZE, 6, depth in words; any value >= 2 (not restricted to a power of two).
- CNT_W, $clog2(MAIN_SIZE+1), width of the occupancy count and threshold ports.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- write  in  1  push request.
- read  in  1  pop request.
- data_in_push  in  DATA_SIZE  push data.
- thr_almost_full  in  CNT_W  almost-full threshold.
- thr_almost_empty  in  CNT_W  almost-empty threshold.
- err_clr  in  1  synchronous clear of fifo_error.
- data_out_pop  out  DATA_SIZE  popped data (registered).
- fifo_count  out  CNT_W  current occupancy.
- Fifo_full  out  1  fifo_count == MAIN_SIZE.
- fifo_empty  out  1  fifo_count == 0.
- almost_full  out  1  fifo_count >= thr_almost_full.
- almost_empty  out  1  fifo_count <= thr_almost_empty.
- fifo_pause  out  1  hysteretic back-pressure to upstream.
- fifo_error  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Clears write pointer, read pointer, fifo_count, data_out_pop, fifo_pause and fifo_error to 0.
  - Outputs become Fifo_full=0, fifo_empty=1; almost_full and almost_empty follow their thresholds against count 0.
  - Storage array is not cleared.
- Read acceptance: rd_ok = read && !fifo_empty.
- Write acceptance: wr_ok = write && (!Fifo_full || rd_ok).
  - When full, a simultaneous read and write are both accepted; count is unchanged and the written word enters the slot freed in the same cycle.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected (underflow), and count becomes 1.
- Pointers: advance by 1 on the accepted operation; wrap from MAIN_SIZE-1 to 0 explicitly. Modulo-2^n wrap is not permitted for a non-power-of-two MAIN_SIZE.
- fifo_count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither are accepted. It never exceeds MAIN_SIZE and never underflows.
- Read latency:
  - data_out_pop updates on the clock edge where rd_ok=1, taking the word at the read pointer. It is valid from that edge, i.e. 1 cycle after read is sampled.
  - It holds its value when no read is accepted.
  - Write-to-read latency: a word written at edge N is poppable by a read sampled at edge N+1.
- Status flags:
  - Fifo_full, fifo_empty, almost_full and almost_empty are combinational from the registered fifo_count and the threshold inputs.
  - Thresholds may change at any time; the flags follow immediately.
- fifo_pause (registered, evaluated on the next-state count):
  - Set when count_next >= thr_almost_full.
  - Cleared when count_next <= thr_almost_empty.
  - Otherwise holds.
  - If thr_almost_empty >= thr_almost_full (invalid programming), fifo_pause = (count_next >= thr_almost_full) with no hysteresis.
  - A threshold of 0 for almost_full forces pause to 1 permanently.
- fifo_error:
  - Set on the edge where (write && !wr_ok) or (read && !rd_ok).
  - Cleared on the edge where err_clr=1 and no new error occurs; a new error in the same cycle as err_clr wins and the flag stays 1.
  - Only reset or err_clr clears it.
- Rejected operations: no change to pointers, count or data_out_pop.

Test Plan (MAIN_SIZE=6, DATA_SIZE=8, thr_almost_full=4, thr_almost_empty=1 unless stated):
- Reset, then write 0x11..0x16 on consecutive cycles:
  - fifo_count steps 1..6.
  - almost_full asserts at count 4; fifo_pause=1 after the edge where count reaches 4.
  - Fifo_full=1 at 6; fifo_error stays 0.
- From full, read 6 times:
  - data_out_pop = 0x11..0x16 in order, each 1 cycle after its read.
  - fifo_pause stays 1 at counts 3 and 2, clears when count reaches 1.
  - almost_empty=1 at counts 1 and 0; fifo_empty=1 at 0.
- Full FIFO, write=1 and read=1 together with data 0xA5:
  - count stays 6, no error.
  - After 6 further reads, 0xA5 emerges last, following the 5 older words (wrap-around check).
- Empty FIFO, read=1:
  - fifo_error=1 next edge; data_out_pop unchanged; count 0.
  - Then err_clr=1 with write=1 and Fifo_full=1 (overflow case, FIFO refilled first): error remains 1.
  - err_clr=1 alone clears it.
- Reset asserted asynchronously mid-burst at count 3 (between clock edges):
  - All outputs return to reset values immediately.
  - The next write/read pair returns the newly written data, not stale entries.
- MAIN_SIZE=5 instance with thr_almost_empty=3, thr_almost_full=2 (invalid programming):
  - fifo_pause tracks count >= 2 without hysteresis.
  - Pointers wrap 4 to 0 across 12 write/read pairs with data integrity.
